// File: rtl/mmio_pkg.sv
// Shared constants and FSM state types for the MMIO peripheral bridge.
package mmio_pkg;

  localparam logic [7:0] UART_DATA_OFF = 8'h00;
  localparam logic [7:0] UART_STAT_OFF = 8'h08;
  localparam logic [7:0] KEY_DATA_OFF  = 8'h10;
  localparam logic [7:0] KEY_STAT_OFF  = 8'h18;

  localparam logic [3:0] IRQ_NONE = 4'd0;
  localparam logic [3:0] IRQ_KEY  = 4'd1;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_IN_SERVICE
  } irq_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_periph_bridge_uart_tx.sv
// 8N1 UART transmit shifter: LSB first, idle-high line, CLKS_PER_BIT cycles per symbol.
module uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (state != TX_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      TX_IDLE: begin
        if (load) begin
          state_n = TX_START;
          cnt_n   = '0;
          shift_n = data;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_n   = TX_DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = TX_STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          state_n = TX_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    // Line level is registered from the next state so txd never glitches.
    txd_n = 1'b1;
    case (state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmio_periph_bridge.sv
// MMIO peripheral window: key receive FIFO with interrupt, and a UART transmit channel.
module mmio_periph_bridge
  import mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_8000_0000,
  parameter int          KEY_FIFO_DEPTH = 8,
  parameter int          CLK_HZ         = 50_000_000,
  parameter int          BAUD           = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_done,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        uart_txd
);

  localparam int CLKS_PER_BIT = ((CLK_HZ / BAUD) < 1) ? 1 : (CLK_HZ / BAUD);
  localparam int AW = $clog2(KEY_FIFO_DEPTH);
  localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

  logic       in_window;
  logic [7:0] off;
  logic       sel_uart_data, sel_uart_stat, sel_key_data, sel_key_stat;
  logic       rd_en_q, wr_en_q, done_q;
  logic       rd_first, wr_first, done_rise;

  assign in_window     = (bus_address[63:8] == BASE_ADDR[63:8]);
  assign off           = bus_address[7:0];
  assign sel_uart_data = in_window && (off == UART_DATA_OFF);
  assign sel_uart_stat = in_window && (off == UART_STAT_OFF);
  assign sel_key_data  = in_window && (off == KEY_DATA_OFF);
  assign sel_key_stat  = in_window && (off == KEY_STAT_OFF);

  assign rd_first  = bus_read_enable && !rd_en_q;
  assign wr_first  = bus_write_enable && !wr_en_q;
  assign done_rise = interrupt_done && !done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= bus_read_enable;
      wr_en_q <= bus_write_enable;
      done_q  <= interrupt_done;
    end
  end

  // Key FIFO: extra pointer bit separates full from empty.
  logic [7:0]  key_mem [KEY_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        nonempty, full, push, pop, overflow;

  assign nonempty = (wr_ptr != rd_ptr);
  assign full     = ((wr_ptr - rd_ptr) == FULL_DIFF);
  assign pop      = rd_first && sel_key_data && nonempty;
  assign push     = key_valid && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (key_valid && full && !pop)    overflow <= 1'b1;
      else if (rd_first && sel_key_stat) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) key_mem[wr_ptr[AW-1:0]] <= key_code;
  end

  // UART holding register feeding the shifter.
  logic       hold_full, tx_busy, tx_load;
  logic [7:0] hold_data;

  assign tx_load = hold_full && !tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
    end else if (wr_first && sel_uart_data && !hold_full) begin
      hold_full <= 1'b1;
    end else if (tx_load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_first && sel_uart_data && !hold_full) hold_data <= bus_write_data[7:0];
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .data  (hold_data),
    .busy  (tx_busy),
    .txd   (uart_txd)
  );

  // Read path. Side-effecting registers keep returning the value seen on the
  // first cycle of an access while the enable stays high.
  logic [63:0] live_data, snap_data;
  logic        use_snap;

  always_comb begin
    live_data = '0;
    if (sel_uart_stat)                 live_data = {62'b0, hold_full, tx_busy};
    else if (sel_key_data && nonempty) live_data = {55'b0, 1'b1, key_mem[rd_ptr[AW-1:0]]};
    else if (sel_key_stat)             live_data = {62'b0, overflow, nonempty};
  end

  always_ff @(posedge clk) begin
    if (rd_first) snap_data <= live_data;
  end

  assign use_snap      = rd_en_q && (sel_key_data || sel_key_stat);
  assign bus_read_data = !bus_read_enable ? 64'b0 : (use_snap ? snap_data : live_data);

  irq_state_e irq_state, irq_state_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_state        <= IRQ_IDLE;
      interrupt_vector <= IRQ_NONE;
    end else begin
      irq_state        <= irq_state_n;
      interrupt_vector <= ((irq_state == IRQ_IDLE) && nonempty) ? IRQ_KEY : IRQ_NONE;
    end
  end

  always_comb begin
    irq_state_n = irq_state;
    case (irq_state)
      IRQ_IDLE:       if (pop)       irq_state_n = IRQ_IN_SERVICE;
      IRQ_IN_SERVICE: if (done_rise) irq_state_n = IRQ_IDLE;
      default:                       irq_state_n = IRQ_IDLE;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^bus_write_data[63:8];

endmodule

// File: tb/tb_mmio_periph_bridge.sv
// Directed bench for mmio_periph_bridge: key FIFO/IRQ reads and UART frames scored against queues.
module tb_mmio_periph_bridge;

  localparam int DEPTH = 8;
  localparam int FRAME_CYC = 160;
  localparam logic [63:0] A_UDATA = 64'h8000_0000;
  localparam logic [63:0] A_USTAT = 64'h8000_0008;
  localparam logic [63:0] A_KDATA = 64'h8000_0010;
  localparam logic [63:0] A_KSTAT = 64'h8000_0018;

  logic        clk;
  logic        reset;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        uart_txd;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int frames_done = 0;
  int frame_start[$];
  logic [63:0] key_q[$];
  logic [7:0]  uart_q[$];
  logic        model_ovf = 1'b0;

  mmio_periph_bridge #(
    .BASE_ADDR      (64'h0000_0000_8000_0000),
    .KEY_FIFO_DEPTH (DEPTH),
    .CLK_HZ         (16),
    .BAUD           (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_done   (interrupt_done),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .uart_txd         (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, frames=%0d", frames_done);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] frame_wave(input logic [7:0] b);
    logic [159:0] w;
    w = '1;
    for (int k = 0; k < 16; k++) w[k] = 1'b0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 16; k++) w[16 + 16*j + k] = b[j];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    if (key_q.size() < DEPTH) key_q.push_back({55'b0, 1'b1, c});
    else model_ovf = 1'b1;
  endtask

  task automatic read_hold(input logic [63:0] addr, input logic [63:0] exp, input int hold, input string tag);
    bus_address     = addr;
    bus_read_enable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1;
      check(tag, 160'(bus_read_data), 160'(exp));
      tick();
    end
    bus_read_enable = 1'b0;
    bus_address     = '0;
    tick();
  endtask

  task automatic read_key(input string tag, input int hold);
    logic [63:0] exp;
    exp = (key_q.size() != 0) ? key_q.pop_front() : 64'h0;
    read_hold(A_KDATA, exp, hold, tag);
  endtask

  task automatic read_kstat(input string tag, input int hold);
    logic [63:0] exp;
    exp = {62'b0, model_ovf, (key_q.size() != 0)};
    read_hold(A_KSTAT, exp, hold, tag);
    model_ovf = 1'b0;
  endtask

  task automatic peek(input logic [63:0] addr, input logic [63:0] exp, input string tag);
    bus_address     = addr;
    bus_read_enable = 1'b1;
    #1;
    check(tag, 160'(bus_read_data), 160'(exp));
    bus_read_enable = 1'b0;
    bus_address     = '0;
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [7:0] d);
    bus_address      = addr;
    bus_write_data   = {56'h0, d};
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
    bus_address      = '0;
    tick();
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (frames_done < n && i < budget) begin
      tick();
      i++;
    end
    check(tag, 160'(frames_done), 160'(n));
  endtask

  // Frame monitor: captures 160 cycles of txd from each falling start edge.
  logic [159:0] mon_wave;
  int           mon_k = 0;
  logic         mon_active = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active = 1'b1;
        mon_wave   = '1;
        mon_wave[0] = 1'b0;
        mon_k      = 1;
        frame_start.push_back(cyc);
      end
    end else begin
      mon_wave[mon_k] = uart_txd;
      mon_k++;
      if (mon_k == FRAME_CYC) begin
        mon_active = 1'b0;
        frames_done++;
        if (uart_q.size() == 0) check("uart_unexpected_frame", mon_wave, '1);
        else check("uart_frame", mon_wave, frame_wave(uart_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus_address = '0;
    bus_write_data = '0;
    bus_write_enable = 1'b0;
    bus_read_enable = 1'b0;
    interrupt_done = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    tick(); tick(); tick();
    check("rst_vector", 160'(interrupt_vector), 160'(4'd0));
    check("rst_txd", 160'(uart_txd), 160'(1'b1));
    check("rst_rdata", 160'(bus_read_data), 160'(64'h0));
    reset = 1'b1;
    tick();
    peek(A_KSTAT, 64'h0, "rst_kstat");
    peek(A_USTAT, 64'h0, "rst_ustat");

    // 1: single key, held read pops once
    push_key(8'h41);
    check("t1_vec_lat", 160'(interrupt_vector), 160'(4'd0));
    tick();
    check("t1_vec", 160'(interrupt_vector), 160'(4'd1));
    read_hold(64'h1_8000_0010, 64'h0, 1, "t1_alias_read");
    peek(64'h8000_0020, 64'h0, "t1_unmapped");
    read_key("t1_key_held", 3);
    check("t1_vec_drop", 160'(interrupt_vector), 160'(4'd0));
    read_kstat("t1_kstat", 1);

    // 2: ISR handshake with a held done level
    interrupt_done = 1'b1;
    repeat (10) tick();
    check("t2_vec_empty", 160'(interrupt_vector), 160'(4'd0));
    push_key(8'h42);
    tick();
    check("t2_vec_42", 160'(interrupt_vector), 160'(4'd1));
    read_key("t2_key42", 1);
    push_key(8'h43);
    repeat (3) tick();
    check("t2_vec_held_done", 160'(interrupt_vector), 160'(4'd0));
    interrupt_done = 1'b0;
    tick();
    interrupt_done = 1'b1;
    tick(); tick();
    check("t2_vec_done_edge", 160'(interrupt_vector), 160'(4'd1));
    read_key("t2_key43", 1);
    interrupt_done = 1'b0;
    tick();

    // 3: overflow
    for (int i = 0; i < 9; i++) push_key(8'h30 + 8'(i));
    tick();
    read_kstat("t3_kstat_ovf", 2);
    for (int i = 0; i < 9; i++) read_key($sformatf("t3_pop%0d", i), 2);
    read_kstat("t3_kstat_clear", 1);

    // 4: one UART frame
    bus_write(A_UDATA, 8'h41);
    uart_q.push_back(8'h41);
    repeat (80) tick();
    peek(A_USTAT, 64'h1, "t4_ustat_busy");
    peek(A_UDATA, 64'h0, "t4_udata_read");
    wait_frames(1, 300, "t4_frames");
    tick(); tick();
    peek(A_USTAT, 64'h0, "t4_ustat_idle");

    // 5: back-to-back writes, third dropped
    bus_write(A_UDATA, 8'h55);
    uart_q.push_back(8'h55);
    bus_write(A_UDATA, 8'hAA);
    uart_q.push_back(8'hAA);
    peek(A_USTAT, 64'h3, "t5_ustat_full");
    bus_write(A_UDATA, 8'h99);
    wait_frames(3, 800, "t5_frames");
    if (frame_start.size() >= 3)
      check("t5_gap", 160'(frame_start[2] - frame_start[1]), 160'(161));
    else
      check("t5_starts", 160'(frame_start.size()), 160'(3));
    repeat (200) tick();
    check("t5_no_third", 160'(frames_done), 160'(3));
    peek(A_USTAT, 64'h0, "t5_ustat_idle");

    // 6: reset in the middle of a frame
    interrupt_done = 1'b1;
    tick();
    interrupt_done = 1'b0;
    tick();
    push_key(8'h77);
    tick();
    check("t6_vec_pre", 160'(interrupt_vector), 160'(4'd1));
    bus_write(A_UDATA, 8'h33);
    repeat (70) tick();
    check("t6_txd_bit3", 160'(uart_txd), 160'(1'b0));
    #1;
    reset = 1'b0;
    #1;
    check("t6_txd_async", 160'(uart_txd), 160'(1'b1));
    check("t6_vec_async", 160'(interrupt_vector), 160'(4'd0));
    key_q.delete();
    model_ovf = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    read_key("t6_key_empty", 1);
    read_kstat("t6_kstat", 1);
    peek(A_USTAT, 64'h0, "t6_ustat");
    repeat (200) tick();
    check("t6_no_frame", 160'(frames_done), 160'(3));
    check("t6_txd_idle", 160'(uart_txd), 160'(1'b1));
    check("t6_uart_q", 160'(uart_q.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
